somador_sequencial: RTL and testbench

//  Multi-cycle parametrised adder/subtractor for the RISC-V datapath. Processes SIZE-bit

---
 rtl/somador_sequencial_pkg.sv | 14 +
 rtl/somador_sequencial_if.sv | 36 +++
 rtl/somador_chunk.sv | 29 ++
 rtl/somador_sequencial.sv | 114 +++++++++++
 tb/tb_somador_sequencial.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/somador_sequencial_pkg.sv
// Shared types and defaults for the chunked sequential adder.
// Imported by the interface, the chunk adder and the top.
package somador_sequencial_pkg;

  localparam int SIZE_DEF  = 32;
  localparam int CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/somador_sequencial_if.sv
// Valid/ready operand and result bundle for somador_sequencial.
// master drives operands and out_ready; slave is the adder.
interface somador_sequencial_if
  import somador_sequencial_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] X;
  logic [SIZE-1:0] Y;
  logic            Cin;
  logic            SUB;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] S;
  logic            Cout;
  logic            Overflow;
  logic            Zero;

  modport master (
    output in_valid, X, Y, Cin, SUB,
    output out_ready,
    input  in_ready, out_valid,
    input  S, Cout, Overflow, Zero
  );

  modport slave (
    input  in_valid, X, Y, Cin, SUB,
    input  out_ready,
    output in_ready, out_valid,
    output S, Cout, Overflow, Zero
  );

endinterface

// File: rtl/somador_chunk.sv
// Combinational CHUNK-bit ripple adder of 1-bit full adders.
// Cmsb is the carry into the top bit, used for signed overflow.
module somador_chunk
  import somador_sequencial_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] X,
  input  logic [CHUNK-1:0] Y,
  input  logic             Cin,
  output logic [CHUNK-1:0] S,
  output logic             Cout,
  output logic             Cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign S[i]   = X[i] ^ Y[i] ^ c[i];
    assign c[i+1] = (X[i] & Y[i])
                  | (c[i] & (X[i] ^ Y[i]));
  end

  assign Cout = c[CHUNK];
  assign Cmsb = c[CHUNK-1];

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle add/sub: SIZE-bit operands, CHUNK bits per clock,
// LSB chunk first, through one shared ripple adder.
module somador_sequencial
  import somador_sequencial_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  somador_sequencial_if.slave bus
);

  localparam int NCHUNKS = SIZE / CHUNK;
  localparam int CW      = $clog2(NCHUNKS) + 1;

  if (SIZE % CHUNK != 0) begin : g_bad_size
    $error("SIZE must be a multiple of CHUNK");
  end

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] s;
  logic [SIZE-1:0] a_sh;
  logic [SIZE-1:0] b_sh;
  logic [SIZE-1:0] s_sh;
  logic            carry;
  logic [CHUNK-1:0] sum;
  logic            c;
  logic            cmsb;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;
  logic            accept;
  logic            last;

  assign accept = bus.in_valid && (state == S_IDLE);
  assign last   = (cnt == CW'(NCHUNKS - 1));

  somador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .X    (a[CHUNK-1:0]),
    .Y    (b[CHUNK-1:0]),
    .Cin  (carry),
    .S    (sum),
    .Cout (c),
    .Cmsb (cmsb)
  );

  // Operands shift down so the active chunk is always at bit 0.
  if (NCHUNKS == 1) begin : g_one
    assign a_sh = '0;
    assign b_sh = '0;
    assign s_sh = sum;
  end else begin : g_many
    assign a_sh = {{CHUNK{1'b0}}, a[SIZE-1:CHUNK]};
    assign b_sh = {{CHUNK{1'b0}}, b[SIZE-1:CHUNK]};
    assign s_sh = {sum, s[SIZE-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept)        state_n = S_CALC;
      S_CALC:  if (last)          state_n = S_DONE;
      S_DONE:  if (bus.out_ready) state_n = S_IDLE;
      default:                    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      s      <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a     <= bus.X;
      b     <= bus.SUB ? ~bus.Y : bus.Y;
      carry <= bus.SUB ? ~bus.Cin : bus.Cin;
      cnt   <= '0;
    end else if (state == S_CALC) begin
      a     <= a_sh;
      b     <= b_sh;
      s     <= s_sh;
      carry <= c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_q <= c;
        ovf_q  <= c ^ cmsb;
        zero_q <= (s_sh == '0);
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.S         = s;
  assign bus.Cout      = cout_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed and randomized checks of somador_sequencial
// with CHUNK=8 (main), CHUNK=4 and CHUNK=32 builds.
module tb_somador_sequencial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  somador_sequencial_if #(.SIZE(32)) b8 ();
  somador_sequencial_if #(.SIZE(32)) b4 ();
  somador_sequencial_if #(.SIZE(32)) b32 ();

  somador_sequencial #(.SIZE(32), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  somador_sequencial #(.SIZE(32), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));
  somador_sequencial #(.SIZE(32), .CHUNK(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op to the CHUNK=8 DUT, return cycles to out_valid.
  task automatic op8(input logic [31:0] x, input logic [31:0] y,
                     input logic cin, input logic sub,
                     output int lat);
    b8.X = x; b8.Y = y; b8.Cin = cin; b8.SUB = sub;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!b8.out_valid) lat = -1;
  endtask

  task automatic pop8;
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({b8.out_valid, b8.S, b8.Cout, b8.Overflow, b8.Zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b S=%h flags=%b%b%b want 0",
               b8.out_valid, b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (b8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", b8.in_ready);
    end
  endtask

  task automatic test_add;
    int lat;
    op8(32'h0000_00FF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    checks++;
    if ({b8.S, b8.Cout, b8.Overflow, b8.Zero} !== {32'h100, 3'b000}) begin
      errors++;
      $display("FAIL add_carry_chain got S=%h C=%b V=%b Z=%b want 00000100 0 0 0",
               b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    pop8();
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_release got ir=%b ov=%b want 1 0",
               b8.in_ready, b8.out_valid);
    end
  endtask

  task automatic test_wrap;
    int lat;
    op8(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if ({b8.S, b8.Cout, b8.Overflow, b8.Zero} !== {32'h0, 3'b101}
        || lat !== 4) begin
      errors++;
      $display("FAIL wrap_zero got S=%h C=%b V=%b Z=%b lat=%0d want 0 1 0 1 4",
               b8.S, b8.Cout, b8.Overflow, b8.Zero, lat);
    end
    pop8();
    op8(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if ({b8.S, b8.Cout, b8.Overflow, b8.Zero} !== {32'h8000_0000, 3'b010}) begin
      errors++;
      $display("FAIL signed_ovf got S=%h C=%b V=%b Z=%b want 80000000 0 1 0",
               b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    pop8();
  endtask

  task automatic test_sub;
    int lat;
    op8(32'd5, 32'd7, 1'b0, 1'b1, lat);
    checks++;
    if ({b8.S, b8.Cout, b8.Overflow, b8.Zero} !== {32'hFFFF_FFFE, 3'b000}) begin
      errors++;
      $display("FAIL sub_borrow got S=%h C=%b V=%b Z=%b want FFFFFFFE 0 0 0",
               b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    pop8();
    op8(32'd7, 32'd5, 1'b1, 1'b1, lat);
    checks++;
    if ({b8.S, b8.Cout, b8.Overflow, b8.Zero} !== {32'h1, 3'b100}) begin
      errors++;
      $display("FAIL sub_borrow_in got S=%h C=%b V=%b Z=%b want 00000001 1 0 0",
               b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    pop8();
  endtask

  task automatic test_hold;
    int lat;
    op8(32'd3, 32'd4, 1'b0, 1'b0, lat);
    b8.X = 32'hAAAA_AAAA; b8.Y = 32'h5555_5555;
    b8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b8.S !== 32'd7 || b8.in_ready !== 1'b0
          || b8.out_valid !== 1'b1 || b8.Zero !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got S=%h ir=%b ov=%b Z=%b want 7 0 1 0",
                 i, b8.S, b8.in_ready, b8.out_valid, b8.Zero);
      end
    end
    b8.in_valid = 1'b0;
    pop8();
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.S !== 32'd7) begin
      errors++;
      $display("FAIL hold_release got ir=%b ov=%b S=%h want 1 0 7",
               b8.in_ready, b8.out_valid, b8.S);
    end
    b8.out_ready = 1'b1;
    tick(); tick();
    b8.out_ready = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_out_ready got ir=%b ov=%b want 1 0",
               b8.in_ready, b8.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    b8.X = 32'h1234_5678; b8.Y = 32'h1111_1111;
    b8.Cin = 1'b0; b8.SUB = 1'b0;
    b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({b8.out_valid, b8.S, b8.Cout, b8.Overflow, b8.Zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b S=%h flags=%b%b%b want 0",
               b8.out_valid, b8.S, b8.Cout, b8.Overflow, b8.Zero);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (b8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got %b want 1", b8.in_ready);
    end
    op8(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    checks++;
    if (b8.S !== 32'h2345_6789 || lat !== 4) begin
      errors++;
      $display("FAIL reset_mid_next got S=%h lat=%0d want 23456789 4",
               b8.S, lat);
    end
    pop8();
  endtask

  task automatic test_random_c4;
    logic [31:0] x, y, bb;
    logic        cin, sub, ci, ev;
    logic [32:0] r;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      x = $urandom; y = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      bb = sub ? ~y : y;
      ci = sub ? ~cin : cin;
      r  = {1'b0, x} + {1'b0, bb} + 33'(ci);
      ev = (x[31] == bb[31]) && (r[31] != x[31]);
      b4.X = x; b4.Y = y; b4.Cin = cin; b4.SUB = sub;
      b4.in_valid = 1'b1;
      tick();
      b4.in_valid = 1'b0;
      lat = 0;
      while (!b4.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if ({b4.Cout, b4.S, b4.Overflow, b4.Zero}
          !== {r, ev, r[31:0] == 32'h0} || lat !== 8) begin
        errors++;
        $display("FAIL rand_c4_%0d got C=%b S=%h V=%b Z=%b lat=%0d want %b %h %b 8",
                 i, b4.Cout, b4.S, b4.Overflow, b4.Zero, lat,
                 r[32], r[31:0], ev);
      end
      b4.out_ready = 1'b1;
      tick();
      b4.out_ready = 1'b0;
    end
  endtask

  task automatic test_random_c32;
    logic [31:0] x, y, bb;
    logic        cin, sub, ci, ev;
    logic [32:0] r;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      x = $urandom; y = $urandom;
      cin = 1'($urandom); sub = 1'($urandom);
      bb = sub ? ~y : y;
      ci = sub ? ~cin : cin;
      r  = {1'b0, x} + {1'b0, bb} + 33'(ci);
      ev = (x[31] == bb[31]) && (r[31] != x[31]);
      b32.X = x; b32.Y = y; b32.Cin = cin; b32.SUB = sub;
      b32.in_valid = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      lat = 0;
      while (!b32.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if ({b32.Cout, b32.S, b32.Overflow, b32.Zero}
          !== {r, ev, r[31:0] == 32'h0} || lat !== 1) begin
        errors++;
        $display("FAIL rand_c32_%0d got C=%b S=%h V=%b Z=%b lat=%0d want %b %h %b 1",
                 i, b32.Cout, b32.S, b32.Overflow, b32.Zero, lat,
                 r[32], r[31:0], ev);
      end
      b32.out_ready = 1'b1;
      tick();
      b32.out_ready = 1'b0;
    end
  endtask

  initial begin
    b8.in_valid = 1'b0;  b8.out_ready = 1'b0;
    b8.X = '0; b8.Y = '0; b8.Cin = 1'b0; b8.SUB = 1'b0;
    b4.in_valid = 1'b0;  b4.out_ready = 1'b0;
    b4.X = '0; b4.Y = '0; b4.Cin = 1'b0; b4.SUB = 1'b0;
    b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    b32.X = '0; b32.Y = '0; b32.Cin = 1'b0; b32.SUB = 1'b0;
    test_reset();
    test_add();
    test_wrap();
    test_sub();
    test_hold();
    test_reset_mid();
    test_random_c4();
    test_random_c32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
